// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port, byte-enabled MEM-stage data memory between the core
// load/store path (m0) and the debug/program-loader port (m1). One access is
// granted per cycle; its fields are muxed onto the mem_* outputs in the same
// cycle. Alignment and funct3 legality are checked at grant time: bad accesses
// are still granted but never strobe the memory, and respond with err=1.
// The returned word is registered in the grant cycle and sign/zero-extended
// on the way out, so the granted port sees a one-cycle-latency response.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration (one-bit pointer)
//                   undefined -> fixed priority (m0 wins ties) with a
//                                starvation guard that lets m1 win after
//                                MAX_WAIT consecutive losing cycles
//
// Parameters:
//   DATA_WIDTH  address/data width (only 32 is supported)
//   MAX_WAIT    starvation threshold for m1 in fixed-priority mode (1..255)
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mX_req_i                     access request, held until granted
//   mX_we_i                      1 = store, 0 = load
//   mX_funct3_i                  RV32I load/store funct3
//   mX_addr_i, mX_wdata_i        byte address, LSB-aligned store data
//   mX_gnt_o                     combinational grant
//   mX_rvalid_o                  one-cycle response pulse
//   mX_rdata_o                   extended load data (0 for stores/errors)
//   mX_err_o                     misaligned/illegal access, qualified by rvalid
//   mem_re_o, mem_we_o           memory read/write strobes
//   mem_funct3_o                 funct3 forwarded to the memory
//   mem_addr_o, mem_wdata_o      memory address and write data
//   mem_rdata_i                  combinational word read from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [2:0]            m0_funct3_i,
  input  logic [DATA_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,

  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [2:0]            m1_funct3_i,
  input  logic [DATA_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,

  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [2:0]            mem_funct3_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  // Legality: funct3[1:0]=11 is never a load/store size, stores have no
  // unsigned variants, and LBU/LHU exist but "LWU" (110) does not on RV32I.
  function automatic logic f_access_ok(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] lo);
    logic ok;
    ok = (f3[1:0] != 2'b11) && !(f3[2] && (we || f3[1]));
    case (f3[1:0])
      2'b01:   ok = ok && !lo[0];
      2'b10:   ok = ok && (lo == 2'b00);
      default: ok = ok;
    endcase
    return ok;
  endfunction

  logic                  w_m1_wins;
  logic                  w_m0_wins;
  logic                  w_gnt;
  logic                  w_sel_we;
  logic [2:0]            w_sel_f3;
  logic [DATA_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_ok;

  logic                  r_rvalid_m0;
  logic                  r_rvalid_m1;
  logic                  r_err;
  logic                  r_load;
  logic [2:0]            r_f3;
  logic [1:0]            r_lane;
  logic [DATA_WIDTH-1:0] r_word;

`ifdef DMEM_ARB_RR_EN
  // r_ptr names the requester preferred on a tie (0 = m0, 1 = m1).
  logic r_ptr;

  assign w_m1_wins = m1_req_i & (~m0_req_i | r_ptr);

  // After each grant the preference moves to the requester that did not win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_gnt) begin
      r_ptr <= m0_gnt_o;
    end
  end
`else
  localparam logic [7:0] LP_MAX_WAIT = MAX_WAIT[7:0];

  logic [7:0] r_wait_cnt;

  assign w_m1_wins = m1_req_i & (~m0_req_i | (r_wait_cnt == LP_MAX_WAIT));

  // Count consecutive cycles m1 waits; saturates so that m1 keeps winning
  // contested cycles only until it is actually served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (!m1_req_i || m1_gnt_o) begin
      r_wait_cnt <= 8'd0;
    end else if (r_wait_cnt != LP_MAX_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`endif

  assign w_m0_wins = m0_req_i & ~w_m1_wins;

  // Grants are suppressed while reset is held so nothing reaches the memory.
  assign m0_gnt_o = rst_n & w_m0_wins;
  assign m1_gnt_o = rst_n & w_m1_wins;
  assign w_gnt    = m0_gnt_o | m1_gnt_o;

  // Route the winner onto the memory side; all zero when nobody is granted.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_f3    = 3'b000;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (m1_gnt_o) begin
      w_sel_we    = m1_we_i;
      w_sel_f3    = m1_funct3_i;
      w_sel_addr  = m1_addr_i;
      w_sel_wdata = m1_wdata_i;
    end else if (m0_gnt_o) begin
      w_sel_we    = m0_we_i;
      w_sel_f3    = m0_funct3_i;
      w_sel_addr  = m0_addr_i;
      w_sel_wdata = m0_wdata_i;
    end
  end

  assign w_ok         = f_access_ok(w_sel_we, w_sel_f3, w_sel_addr[1:0]);
  assign mem_re_o     = w_gnt & w_ok & ~w_sel_we;
  assign mem_we_o     = w_gnt & w_ok & w_sel_we;
  assign mem_funct3_o = w_sel_f3;
  assign mem_addr_o   = w_sel_addr;
  assign mem_wdata_o  = w_sel_wdata;

  // Capture everything the response needs in the grant cycle. The word is
  // only kept for legal loads so stores and errors answer with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid_m0 <= 1'b0;
      r_rvalid_m1 <= 1'b0;
      r_err       <= 1'b0;
      r_load      <= 1'b0;
      r_f3        <= 3'b000;
      r_lane      <= 2'b00;
      r_word      <= '0;
    end else begin
      r_rvalid_m0 <= m0_gnt_o;
      r_rvalid_m1 <= m1_gnt_o;
      if (w_gnt) begin
        r_err  <= ~w_ok;
        r_load <= w_ok & ~w_sel_we;
        r_f3   <= w_sel_f3;
        r_lane <= w_sel_addr[1:0];
        r_word <= (w_ok && !w_sel_we) ? mem_rdata_i : '0;
      end
    end
  end

  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ext;

  // Lane selection and sign/zero extension of the registered word.
  always_comb begin
    w_byte = 8'h00;
    w_half = r_lane[1] ? r_word[31:16] : r_word[15:0];
    w_ext  = '0;
    case (r_lane)
      2'b00:   w_byte = r_word[7:0];
      2'b01:   w_byte = r_word[15:8];
      2'b10:   w_byte = r_word[23:16];
      default: w_byte = r_word[31:24];
    endcase
    if (r_load) begin
      case (r_f3)
        3'b000:  w_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
        3'b100:  w_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
        3'b001:  w_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        3'b101:  w_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
        3'b010:  w_ext = r_word;
        default: w_ext = '0;
      endcase
    end
  end

  assign m0_rvalid_o = r_rvalid_m0;
  assign m1_rvalid_o = r_rvalid_m1;
  assign m0_err_o    = r_rvalid_m0 & r_err;
  assign m1_err_o    = r_rvalid_m1 & r_err;
  assign m0_rdata_o  = r_rvalid_m0 ? w_ext : '0;
  assign m1_rdata_o  = r_rvalid_m1 ? w_ext : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with MAX_WAIT=3. Inputs change on the
// falling edge; outputs are sampled 1 ns later, well away from the rising
// edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req_i, m0_we_i;
  logic [2:0]  m0_funct3_i;
  logic [31:0] m0_addr_i, m0_wdata_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i, m1_we_i;
  logic [2:0]  m1_funct3_i;
  logic [31:0] m1_addr_i, m1_wdata_i;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_rdata_o;
  logic        mem_re_o, mem_we_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int totalChecks = 0;
  int badChecks   = 0;

  dmem_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_funct3_i(m0_funct3_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_funct3_i(m1_funct3_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_funct3_o(mem_funct3_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Raise one requester with the given access; memWord is what the memory
  // returns combinationally this cycle.
  task automatic applyStimulus(input bit useM1, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] memWord);
    if (useM1) begin
      m1_req_i = 1'b1; m1_we_i = we; m1_funct3_i = f3; m1_addr_i = addr; m1_wdata_i = wdata;
    end else begin
      m0_req_i = 1'b1; m0_we_i = we; m0_funct3_i = f3; m0_addr_i = addr; m0_wdata_i = wdata;
    end
    mem_rdata_i = memWord;
  endtask

  // Drop both requests and park all inputs at zero.
  task automatic clearRequests();
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_funct3_i = 3'b000; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_funct3_i = 3'b000; m1_addr_i = '0; m1_wdata_i = '0;
    mem_rdata_i = '0;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Arbitration sequence with both requesting continuously from reset.
`ifdef DMEM_ARB_RR_EN
  logic expG0[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic expG1[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic DROP_WINNER_M1 = 1'b1;
`else
  logic expG0[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic expG1[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic DROP_WINNER_M1 = 1'b0;
`endif

  // Load extension vectors, all against memory word 0x80FF7F01.
  logic [2:0]  ldF3[7]   = '{3'b000, 3'b101, 3'b001, 3'b001, 3'b100, 3'b000, 3'b010};
  logic [31:0] ldAddr[7] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h103, 32'h100, 32'h100};
  logic [31:0] ldExp[7]  = '{32'hFFFFFFFF, 32'h000080FF, 32'hFFFF80FF, 32'h00007F01,
                             32'h00000080, 32'h00000001, 32'h80FF7F01};

  initial begin
    $display("[TB] dmem_arbiter directed test start");
    clearRequests();
    rst_n = 1'b0;

    // Reset: a request is present but nothing may be granted or strobed.
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h11223344);
    #2;
    checkOutput("rst_gnt0", {31'b0, m0_gnt_o}, 32'd0);
    checkOutput("rst_mem_re", {31'b0, mem_re_o}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_rvalid0", {31'b0, m0_rvalid_o}, 32'd0);
    checkOutput("rst_rdata0", m0_rdata_o, 32'd0);
    checkOutput("rst_err1", {31'b0, m1_err_o}, 32'd0);
    @(negedge clk);
    clearRequests();
    rst_n = 1'b1;

    // Both requesting continuously: starvation guard / round robin.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678);
    for (int i = 0; i <= 5; i++) begin
      if (i == 5) clearRequests();
      #1;
      if (i < 5) begin
        checkOutput($sformatf("arb_gnt0_c%0d", i), {31'b0, m0_gnt_o}, {31'b0, expG0[i]});
        checkOutput($sformatf("arb_gnt1_c%0d", i), {31'b0, m1_gnt_o}, {31'b0, expG1[i]});
        checkOutput($sformatf("arb_addr_c%0d", i), mem_addr_o, expG1[i] ? 32'h200 : 32'h100);
      end
      if (i > 0) begin
        checkOutput($sformatf("arb_rv0_c%0d", i), {31'b0, m0_rvalid_o}, {31'b0, expG0[i-1]});
        checkOutput($sformatf("arb_rv1_c%0d", i), {31'b0, m1_rvalid_o}, {31'b0, expG1[i-1]});
        checkOutput($sformatf("arb_rd1_c%0d", i), m1_rdata_o, expG1[i-1] ? 32'h12345678 : 32'h0);
      end
      @(negedge clk);
    end

    // Back-to-back m0 loads with every extension flavour.
    for (int i = 0; i <= 7; i++) begin
      clearRequests();
      if (i < 7) applyStimulus(1'b0, 1'b0, ldF3[i], ldAddr[i], 32'h0, 32'h80FF7F01);
      #1;
      if (i < 7) begin
        checkOutput($sformatf("ld_gnt_%0d", i), {31'b0, m0_gnt_o}, 32'd1);
        checkOutput($sformatf("ld_re_%0d", i), {31'b0, mem_re_o}, 32'd1);
      end
      if (i > 0) begin
        checkOutput($sformatf("ld_rvalid_%0d", i-1), {31'b0, m0_rvalid_o}, 32'd1);
        checkOutput($sformatf("ld_rdata_%0d", i-1), m0_rdata_o, ldExp[i-1]);
        checkOutput($sformatf("ld_err_%0d", i-1), {31'b0, m0_err_o}, 32'd0);
      end
      @(negedge clk);
    end

    // Misaligned SW from m1: granted, no write strobe.
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h206, 32'hCAFEF00D, 32'h0);
    #1;
    checkOutput("sw_mis_gnt1", {31'b0, m1_gnt_o}, 32'd1);
    checkOutput("sw_mis_gnt0", {31'b0, m0_gnt_o}, 32'd0);
    checkOutput("sw_mis_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("sw_mis_re", {31'b0, mem_re_o}, 32'd0);

    // Legal SW from m1 back to back with the error response.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h204, 32'hDEADBEEF, 32'h55555555);
    #1;
    checkOutput("sw_mis_rvalid1", {31'b0, m1_rvalid_o}, 32'd1);
    checkOutput("sw_mis_err1", {31'b0, m1_err_o}, 32'd1);
    checkOutput("sw_mis_rdata1", m1_rdata_o, 32'd0);
    checkOutput("sw_mis_rvalid0", {31'b0, m0_rvalid_o}, 32'd0);
    checkOutput("sw_we", {31'b0, mem_we_o}, 32'd1);
    checkOutput("sw_addr", mem_addr_o, 32'h204);
    checkOutput("sw_wdata", mem_wdata_o, 32'hDEADBEEF);
    checkOutput("sw_f3", {29'b0, mem_funct3_o}, 32'd2);

    // Illegal funct3 (011) load from m0.
    @(negedge clk);
    clearRequests();
    applyStimulus(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h77777777);
    #1;
    checkOutput("sw_rvalid1", {31'b0, m1_rvalid_o}, 32'd1);
    checkOutput("sw_err1", {31'b0, m1_err_o}, 32'd0);
    checkOutput("sw_rdata1", m1_rdata_o, 32'd0);
    checkOutput("ill_gnt0", {31'b0, m0_gnt_o}, 32'd1);
    checkOutput("ill_re", {31'b0, mem_re_o}, 32'd0);

    // Misaligned LH from m0.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b001, 32'h101, 32'h0, 32'h77777777);
    #1;
    checkOutput("ill_err0", {31'b0, m0_err_o}, 32'd1);
    checkOutput("ill_rdata0", m0_rdata_o, 32'd0);
    checkOutput("lh_mis_re", {31'b0, mem_re_o}, 32'd0);

    // Idle: memory side fully zero.
    @(negedge clk);
    clearRequests();
    #1;
    checkOutput("lh_mis_err0", {31'b0, m0_err_o}, 32'd1);
    checkOutput("idle_re", {31'b0, mem_re_o}, 32'd0);
    checkOutput("idle_we", {31'b0, mem_we_o}, 32'd0);
    checkOutput("idle_addr", mem_addr_o, 32'd0);
    checkOutput("idle_wdata", mem_wdata_o, 32'd0);
    checkOutput("idle_f3", {29'b0, mem_funct3_o}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("idle_rvalid0", {31'b0, m0_rvalid_o}, 32'd0);
    checkOutput("idle_err0", {31'b0, m0_err_o}, 32'd0);

    // Contested cycle, then the loser drops its request: no response for it.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0);
    #1;
    checkOutput("drop_gnt1", {31'b0, m1_gnt_o}, {31'b0, DROP_WINNER_M1});
    @(negedge clk);
    clearRequests();
    #1;
    checkOutput("drop_rv0", {31'b0, m0_rvalid_o}, {31'b0, ~DROP_WINNER_M1});
    checkOutput("drop_rv1", {31'b0, m1_rvalid_o}, {31'b0, DROP_WINNER_M1});
    @(negedge clk);
    #1;
    checkOutput("drop_none0", {31'b0, m0_rvalid_o}, 32'd0);
    checkOutput("drop_none1", {31'b0, m1_rvalid_o}, 32'd0);

    // Reset in the cycle after a grant drops the pending response.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h80FF7F01);
    #1;
    checkOutput("rmid_gnt0", {31'b0, m0_gnt_o}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_rvalid0", {31'b0, m0_rvalid_o}, 32'd0);
    checkOutput("rmid_rdata0", m0_rdata_o, 32'd0);
    @(negedge clk);
    clearRequests();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("rmid_after_rv0_%0d", i), {31'b0, m0_rvalid_o}, 32'd0);
      checkOutput($sformatf("rmid_after_rd0_%0d", i), m0_rdata_o, 32'd0);
      checkOutput($sformatf("rmid_after_err0_%0d", i), {31'b0, m0_err_o}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port, byte-enabled data memory in the MEM stage. It shares the memory between the core load/store path (m0) and the debug/program-loader port (m1), checks alignment, and drives the memory's read/write strobes, funct3, address and write data. It registers the returned word and sign/zero-extends it per load type, delivering a one-cycle-latency response to the granted requester.

## Interface
- DATA_WIDTH, 32: address/data width; only 32 is supported.
- MAX_WAIT, 8: fixed-priority mode only. Number of consecutive losing cycles after which m1 is forced to win; range 1–255.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req_i / m1_req_i  in  1  access request; held until granted.
- m0_we_i / m1_we_i  in  1  1 = store, 0 = load.
- m0_funct3_i / m1_funct3_i  in  3  RV32I load/store funct3.
- m0_addr_i / m1_addr_i  in  DATA_WIDTH  byte address.
- m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  store data, LSB-aligned.
- m0_gnt_o / m1_gnt_o  out  1  access accepted this cycle; combinational.
- m0_rvalid_o / m1_rvalid_o  out  1  one-cycle response pulse.
- m0_rdata_o / m1_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- m0_err_o / m1_err_o  out  1  misaligned or illegal access; qualified by rvalid.
- mem_re_o, mem_we_o  out  1  memory read/write strobes.
- mem_funct3_o  out  3  funct3 forwarded to the memory.
- mem_addr_o, mem_wdata_o  out  DATA_WIDTH  memory address and write data.
- mem_rdata_i  in  DATA_WIDTH  combinational word read from the memory.

## Operation
- At most one grant per cycle. The granted requester's fields are muxed onto the mem_* outputs in the same cycle.
- **Alignment check:**
  - Byte accesses (LB/LBU/SB) are always aligned.
  - Halfword accesses (LH/LHU/SH) require addr[0]=0.
  - Word accesses (LW/SW) require addr[1:0]=0.
  - Any other funct3 (3'b011, 3'b110, 3'b111, or a store with funct3[2]=1) is illegal.
- **Misaligned or illegal access:**
  - It is still granted.
  - mem_re_o = mem_we_o = 0.
  - The response carries err=1 and rdata=0.
- **Legal load:** mem_re_o=1. The arbiter captures mem_rdata_i, funct3 and addr[1:0] in the grant cycle.
- **Legal store:** mem_we_o=1. The memory applies byte enables itself.
- **Load extension** (lane selected by addr[1:0]):
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LH uses lane addr[1]; LW passes the word through.
- **Priority:**
  - Fixed priority (default): m0 wins ties.
  - A wait counter increments each cycle that m1 requests and is not granted; it saturates at MAX_WAIT.
  - When the counter equals MAX_WAIT, m1 wins the next contested cycle.
  - The counter clears whenever m1 is granted or m1_req_i is low.
- No requests: all mem_* strobes are 0; the address/data/funct3 outputs are 0.

## Timing
- Grant latency is 0 cycles: gnt_o rises in the same cycle as req if the requester wins.
- Response: in cycle N+1 after a grant in cycle N, the granted port's rvalid_o=1 for exactly one cycle, with rdata_o/err_o valid.
- Back-to-back grants are allowed: with grants in cycles N and N+1, responses appear in N+1 and N+2.
- A request dropped before being granted is legal and produces no response.
- **Reset values:**
  - All rvalid, err and rdata outputs are 0; wait counter = 0; priority pointer = m0.
  - While rst_n=0, gnt_o and mem_re_o/mem_we_o are forced to 0.
- Reset asserted during the cycle after a grant drops the pending response; no rvalid follows deassertion.

## Configuration
- **DMEM_ARB_RR_EN defined:** round-robin arbitration.
  - A one-bit pointer names the preferred requester and toggles to the other requester after every grant.
  - MAX_WAIT and the wait counter are not implemented.
- **DMEM_ARB_RR_EN undefined:** fixed priority with the MAX_WAIT starvation guard described above.

## Test plan
- **Fixed-priority starvation guard:** m0 and m1 request continuously, MAX_WAIT=3 -> m0 is granted cycles 0–2, m1 in cycle 3, then m0 again.
- **LB sign-extension:** m0 issues LB addr=0x102, memory word 0x80FF7F01 -> next cycle m0_rvalid_o=1, m0_rdata_o=0xFFFFFFFF.
- **LHU zero-extension:** m0 issues LHU addr=0x102 on the same word -> m0_rdata_o=0x000080FF.
- **Misaligned store:** m1 issues SW addr=0x206 -> m1_gnt_o=1, mem_we_o=0; next cycle m1_rvalid_o=1, m1_err_o=1, m1_rdata_o=0.
- **Round-robin (DMEM_ARB_RR_EN defined):** both request for 4 cycles -> grants go m0, m1, m0, m1, and responses alternate one cycle later.
- **Reset mid-response:** m0 LW granted in cycle N, rst_n low in cycle N+1 -> m0_rvalid_o stays 0, and all outputs stay 0 until the next grant.
